// File: rtl/mips_pkg.sv
// Shared constants and the fetch-action encoding used by the IF stage.
package mips_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned WORD_SHIFT = 2;

    localparam logic [INSTR_W-1:0] MIPS_NOP = 32'h0;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        REDIRECT,
        FAULT
    } fetch_action_e;

endpackage

// File: rtl/mips_next_pc_sel.sv
// Combinational next-PC selection for the IF stage: fault > redirect > stall > sequential.
module mips_next_pc_sel
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 2048
) (
    input  logic [INSTR_W-1:0] pc,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [INSTR_W-1:0] branch_target,
    input  logic               jump,
    input  logic [INSTR_W-1:0] jump_target,
    input  logic               fetch_fault,
    output logic [INSTR_W-1:0] next_pc,
    output fetch_action_e      action,
    output logic               fault_det
);

    // One extra bit so the byte limit stays exact for any IMEM_WORDS.
    localparam logic [INSTR_W:0] IMEM_BYTES = 33'(IMEM_WORDS) << WORD_SHIFT;

    logic               redirect;
    logic [INSTR_W-1:0] cand;

    always_comb begin
        redirect  = branch_taken | jump;
        cand      = branch_taken ? branch_target :
                    jump         ? jump_target   : pc + 32'd4;
        next_pc   = pc;
        action    = HOLD;
        fault_det = 1'b0;
        if (!fetch_fault && (redirect || !stall)) begin
            fault_det = (cand[WORD_SHIFT-1:0] != '0) || ({1'b0, cand} >= IMEM_BYTES);
            next_pc   = cand;
            if (fault_det) begin
                action = FAULT;
            end else if (redirect) begin
                action = REDIRECT;
            end else begin
                action = FETCH;
            end
        end
    end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS IF stage: PC register, IF/ID pipeline register, perf counters and sticky fetch fault.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 2048,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic               imem_memread,
    output logic [31:0]        imem_address,
    input  logic [31:0]        imem_readdata,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic               fetch_fault,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   stall_count
);

    logic [31:0]   pc_q;
    logic [31:0]   next_pc;
    fetch_action_e action;
    logic          fault_det;
    logic          capture;
    logic          flush;
    logic          hold;

    mips_next_pc_sel #(
        .IMEM_WORDS(IMEM_WORDS)
    ) u_next_pc_sel (
        .pc           (pc_q),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .fetch_fault  (fetch_fault),
        .next_pc      (next_pc),
        .action       (action),
        .fault_det    (fault_det)
    );

    assign imem_address = pc_q;
    assign imem_memread = ~fetch_fault;

    // A sequential step past the end still captures the last legal word; only the
    // wrapped PC is faulty. A faulting redirect discards the wrong-path fetch.
    always_comb begin
        capture = 1'b0;
        flush   = 1'b0;
        hold    = 1'b0;
        if (!fetch_fault) begin
            unique case (action)
                FETCH:    capture = 1'b1;
                HOLD:     hold    = 1'b1;
                REDIRECT: flush   = 1'b1;
                FAULT: begin
                    capture = ~(branch_taken | jump);
                    flush   = branch_taken | jump;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            if_id_instr <= MIPS_NOP;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (capture || flush) begin
                pc_q <= next_pc;
            end
            if (fault_det && !fetch_fault) begin
                fetch_fault <= 1'b1;
            end
            if (capture) begin
                if_id_instr <= imem_readdata;
                if_id_pc4   <= pc_q + 32'd4;
                if_id_valid <= 1'b1;
                if (!(&fetch_count)) begin
                    fetch_count <= fetch_count + CNT_W'(1);
                end
            end
            if (flush) begin
                if_id_instr <= MIPS_NOP;
                if_id_pc4   <= '0;
                if_id_valid <= 1'b0;
            end
            if (hold && !(&stall_count)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed plan followed by random redirects/stalls.
module tb_mips_fetch_stage;
    import mips_pkg::*;

    localparam int unsigned IMEM_WORDS = 2048;
    localparam int unsigned CNT_W      = 4;
    localparam int          CMAX       = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic              jump;
    logic [31:0]       jump_target;
    logic              imem_memread;
    logic [31:0]       imem_address;
    logic [31:0]       imem_readdata;
    logic [31:0]       if_id_instr;
    logic [31:0]       if_id_pc4;
    logic              if_id_valid;
    logic              fetch_fault;
    logic [CNT_W-1:0]  fetch_count;
    logic [CNT_W-1:0]  stall_count;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_fault;
    int          m_fc;
    int          m_sc;

    mips_fetch_stage #(
        .RESET_PC  (32'h0),
        .IMEM_WORDS(IMEM_WORDS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_memread (imem_memread),
        .imem_address (imem_address),
        .imem_readdata(imem_readdata),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fetch_fault  (fetch_fault),
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_fc    = 0;
        m_sc    = 0;
    endtask

    // One clock edge of the fetch stage, straight from the priority rules.
    task automatic model_edge();
        logic [31:0] cand;
        bit          redir;
        if (m_fault) return;
        redir = branch_taken || jump;
        if (!redir && stall) begin
            if (m_sc < CMAX) m_sc++;
            return;
        end
        if (branch_taken)  cand = branch_target;
        else if (jump)     cand = jump_target;
        else               cand = m_pc + 32'd4;
        if (redir) begin
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end else begin
            m_instr = imem_readdata;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            if (m_fc < CMAX) m_fc++;
        end
        if ((cand % 4) != 0 || cand >= IMEM_WORDS * 4) m_fault = 1'b1;
        m_pc = cand;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_address, m_pc);
        check({tag, ".rd"},    32'(imem_memread), 32'(!m_fault));
        check({tag, ".instr"}, if_id_instr, m_instr);
        check({tag, ".pc4"},   if_id_pc4, m_pc4);
        check({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
        check({tag, ".fault"}, 32'(fetch_fault), 32'(m_fault));
        check({tag, ".fc"},    32'(fetch_count), 32'(m_fc));
        check({tag, ".sc"},    32'(stall_count), 32'(m_sc));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
    endtask

    // Assert reset between edges, check the asynchronous effect, release after an edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all({tag, ".rel"});
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        imem_readdata = 32'h0;
        model_reset();
        #2;
        check_all("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("rst_rel");

        // Sequential fetch
        imem_readdata = 32'h11; tick("seq0");
        imem_readdata = 32'h22; tick("seq1");
        imem_readdata = 32'h33; tick("seq2");
        check("seq.instr", if_id_instr, 32'h33);
        check("seq.pc4", if_id_pc4, 32'd12);
        check("seq.fc", 32'(fetch_count), 32'd3);

        // Stall holds PC and IF/ID
        stall = 1'b1; imem_readdata = 32'h44;
        tick("stall0");
        tick("stall1");
        check("stall.addr", imem_address, 32'd12);
        check("stall.sc", 32'(stall_count), 32'd2);
        stall = 1'b0;
        tick("unstall");

        // Branch overrides a simultaneous stall
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        tick("br_stall");
        check("br.addr", imem_address, 32'h40);
        check("br.valid", 32'(if_id_valid), 32'd0);
        idle_inputs(); imem_readdata = 32'h55;
        tick("br_next");
        check("br.pc4", if_id_pc4, 32'h44);

        // Branch beats jump
        branch_taken = 1'b1; branch_target = 32'h80; jump = 1'b1; jump_target = 32'h100;
        tick("br_jmp");
        check("brjmp.addr", imem_address, 32'h80);

        // Misaligned jump faults and freezes everything
        idle_inputs();
        jump = 1'b1; jump_target = 32'h42;
        tick("jfault");
        check("jfault.addr", imem_address, 32'h42);
        check("jfault.rd", 32'(imem_memread), 32'd0);
        for (int i = 0; i < 5; i++) begin
            stall = 1'(i % 2); branch_taken = 1'(i % 3 == 0); branch_target = 32'h10;
            jump = 1'b1; jump_target = 32'h20;
            tick("frozen");
        end
        idle_inputs();
        do_reset("rst_fault");

        // Run off the end of instruction memory
        jump = 1'b1; jump_target = 32'h1FFC;
        tick("to_end");
        idle_inputs(); imem_readdata = 32'hCAFE_0001;
        tick("last_word");
        check("end.valid", 32'(if_id_valid), 32'd1);
        check("end.instr", if_id_instr, 32'hCAFE_0001);
        check("end.fault", 32'(fetch_fault), 32'd1);
        check("end.addr", imem_address, 32'h2000);
        for (int i = 0; i < 3; i++) tick("end_frozen");
        #2;
        do_reset("rst_mid");

        // Random phase; counters saturate quickly at CNT_W=4
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom % 4) == 0;
            branch_taken  = ($urandom % 8) == 0;
            jump          = ($urandom % 8) == 0;
            branch_target = {19'h0, 11'($urandom), 2'b00};
            jump_target   = {19'h0, 11'($urandom), 2'b00};
            if ($urandom % 16 == 0) branch_target = $urandom;
            if ($urandom % 16 == 0) jump_target = $urandom;
            imem_readdata = $urandom;
            tick("rnd");
            if ((m_fault && ($urandom % 4 == 0)) || ($urandom % 64 == 0)) begin
                idle_inputs();
                do_reset("rnd_rst");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
